// File: rtl/seq_adder.sv
// -----------------------------------------------------------------------------
// seq_adder
//   Bit-serial (chunk-serial) adder. Accepts a, b and cin with a valid/ready
//   handshake, adds CHUNK bits per cycle starting from the LSB chunk, then
//   presents sum, cout and ovf with a valid/ready handshake until consumed.
//
// State table
//   state | meaning
//   IDLE  | waiting for operands, in_ready=1
//   RUN   | adding chunk k_q of the captured operands each cycle
//   DONE  | result held; out_valid raised after one settle cycle
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands on a/b/cin are valid
//   in_ready   block can accept operands (IDLE only)
//   a, b       WIDTH-bit operands
//   cin        carry-in
//   out_valid  result valid (DONE only)
//   out_ready  consumer accepts the result
//   sum        a + b + cin modulo 2^WIDTH
//   cout       carry out of bit WIDTH-1
//   ovf        signed overflow (carry into MSB xor carry out of MSB)
// -----------------------------------------------------------------------------
module seq_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int SW     = $clog2(WIDTH) + 1;

  localparam logic [KW-1:0]    K_LAST     = KW'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [KW-1:0]    k_q, k_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;

  // Chunk datapath: select chunk k of each operand and add with the carry.
  logic [SW-1:0]    shamt;
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK:0]   chunk_sum;
  logic             msb_carry_in;
  logic [WIDTH-1:0] sum_merged;

  assign shamt     = SW'(k_q) * SW'(CHUNK);
  assign a_chunk   = CHUNK'(a_q >> shamt);
  assign b_chunk   = CHUNK'(b_q >> shamt);
  assign chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};

  // Carry into the top bit of the chunk recovered from its sum bit:
  // s = a ^ b ^ c_in  =>  c_in = a ^ b ^ s. Only meaningful on the last chunk,
  // where that top bit is bit WIDTH-1.
  assign msb_carry_in = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ chunk_sum[CHUNK-1];

  assign sum_merged = (sum_q & ~(CHUNK_MASK << shamt))
                    | (WIDTH'(chunk_sum[CHUNK-1:0]) << shamt);

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    k_d         = k_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          k_d     = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        sum_d   = sum_merged;
        carry_d = chunk_sum[CHUNK];
        k_d     = k_q + 1'b1;
        if (k_q == K_LAST) begin
          cout_d  = chunk_sum[CHUNK];
          ovf_d   = msb_carry_in ^ chunk_sum[CHUNK];
          k_d     = '0;
          state_d = DONE;
        end
      end

      DONE: begin
        // First DONE cycle only raises out_valid; this fixes the latency at
        // NCHUNK+1 edges. out_ready is ignored until out_valid is visible.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      k_q         <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      k_q         <= k_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_seq_adder.sv
// -----------------------------------------------------------------------------
// tb_seq_adder
//   Four seq_adder instances (WIDTH=8, CHUNK=1,2,4,8) run side by side. A
//   transaction-level model per instance predicts handshake timing and the
//   a+b+cin result; a negedge process compares every cycle.
// -----------------------------------------------------------------------------
module tb_seq_adder;

  localparam int NI = 4;

  logic       clk;
  logic       rst_n;
  logic       in_valid  [NI];
  logic       out_ready [NI];
  logic [7:0] a_in      [NI];
  logic [7:0] b_in      [NI];
  logic       cin_in    [NI];
  logic       in_ready_o  [NI];
  logic       out_valid_o [NI];
  logic [7:0] sum_o       [NI];
  logic       cout_o      [NI];
  logic       ovf_o       [NI];

  int n_checks = 0;
  int n_errors = 0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    seq_adder #(.WIDTH(8), .CHUNK(1 << g)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready_o[g]),
      .a         (a_in[g]),
      .b         (b_in[g]),
      .cin       (cin_in[g]),
      .out_valid (out_valid_o[g]),
      .out_ready (out_ready[g]),
      .sum       (sum_o[g]),
      .cout      (cout_o[g]),
      .ovf       (ovf_o[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int       m_wait [NI];   // edges left until result is presented
  bit       m_done [NI];   // result presented, waiting for consumer
  bit [8:0] m_res  [NI];   // {cout, sum}
  bit       m_ovf  [NI];
  int       m_acc  [NI];   // accepted operations

  function automatic int latency(input int i);
    return 8 / (1 << i) + 1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < NI; i++) begin
      if (!rst_n) begin
        m_wait[i] = 0;
        m_done[i] = 0;
      end else if (m_done[i]) begin
        if (out_ready[i]) m_done[i] = 0;
      end else if (m_wait[i] > 0) begin
        m_wait[i]--;
        if (m_wait[i] == 0) m_done[i] = 1;
      end else if (in_valid[i]) begin
        m_res[i]  = 9'(a_in[i]) + 9'(b_in[i]) + 9'(cin_in[i]);
        m_ovf[i]  = (a_in[i][7] == b_in[i][7]) && (m_res[i][7] != a_in[i][7]);
        m_wait[i] = latency(i);
        m_acc[i]++;
      end
    end
  end

  task automatic check(input string nm, input int idx,
                       input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s[chunk=%0d]: got %0h, want %0h", nm, 1 << idx, act, exp);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      check("in_ready",  i, 64'(in_ready_o[i]),  64'(!m_done[i] && m_wait[i] == 0));
      check("out_valid", i, 64'(out_valid_o[i]), 64'(m_done[i]));
      if (m_done[i]) begin
        check("sum",  i, 64'(sum_o[i]),  64'(m_res[i][7:0]));
        check("cout", i, 64'(cout_o[i]), 64'(m_res[i][8]));
        check("ovf",  i, 64'(ovf_o[i]),  64'(m_ovf[i]));
      end
    end
  end

  // Directed operation on all instances. Called at a negedge with all idle.
  // Holds out_ready low for 20 cycles (backpressure) while toggling in_valid
  // and operands, then releases the result.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                        input logic [7:0] es, input logic ec, input logic eo);
    int lat [NI];
    logic [7:0] held [NI];
    for (int i = 0; i < NI; i++) begin
      in_valid[i]  = 1'b1;
      a_in[i]      = ta;
      b_in[i]      = tb_v;
      cin_in[i]    = tc;
      out_ready[i] = 1'b0;
      lat[i]       = 0;
      held[i]      = '0;
    end
    @(negedge clk);
    for (int i = 0; i < NI; i++) in_valid[i] = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        if (out_valid_o[i] && lat[i] == 0) begin
          lat[i]  = cyc;
          held[i] = sum_o[i];
        end
        in_valid[i] = 1'($urandom_range(0, 1));
        a_in[i]     = 8'($urandom);
        b_in[i]     = 8'($urandom);
        cin_in[i]   = 1'($urandom_range(0, 1));
      end
    end
    for (int i = 0; i < NI; i++) begin
      check("latency",    i, 64'(lat[i]),         64'(latency(i)));
      check("lit_sum",    i, 64'(sum_o[i]),       64'(es));
      check("lit_cout",   i, 64'(cout_o[i]),      64'(ec));
      check("lit_ovf",    i, 64'(ovf_o[i]),       64'(eo));
      check("hold_sum",   i, 64'(sum_o[i]),       64'(held[i]));
      check("hold_valid", i, 64'(out_valid_o[i]), 64'(1));
      check("hold_ready", i, 64'(in_ready_o[i]),  64'(0));
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b1;
    end
    @(negedge clk);
    for (int i = 0; i < NI; i++) out_ready[i] = 1'b0;
  endtask

  initial begin
    int base [NI];
    bit all_done;
    for (int i = 0; i < NI; i++) begin
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b0;
      a_in[i]      = '0;
      b_in[i]      = '0;
      cin_in[i]    = 1'b0;
    end
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    for (int i = 0; i < NI; i++) begin
      check("rst_in_ready",  i, 64'(in_ready_o[i]),  64'(1));
      check("rst_out_valid", i, 64'(out_valid_o[i]), 64'(0));
      check("rst_sum",       i, 64'(sum_o[i]),       64'(0));
      check("rst_cout",      i, 64'(cout_o[i]),      64'(0));
      check("rst_ovf",       i, 64'(ovf_o[i]),       64'(0));
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    // Operands presented at release: accepted on the first edge.
    run_op(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op(8'h80, 8'hFF, 1'b1, 8'h80, 1'b1, 1'b0);
    run_op(8'h9C, 8'h67, 1'b1, 8'h04, 1'b1, 1'b0);

    // Reset while chunk 3 is in progress.
    for (int i = 0; i < NI; i++) begin
      in_valid[i] = 1'b1;
      a_in[i]     = 8'h55;
      b_in[i]     = 8'h33;
      cin_in[i]   = 1'b0;
    end
    @(negedge clk);
    for (int i = 0; i < NI; i++) in_valid[i] = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      check("abort_in_ready",  i, 64'(in_ready_o[i]),  64'(1));
      check("abort_out_valid", i, 64'(out_valid_o[i]), 64'(0));
      check("abort_sum",       i, 64'(sum_o[i]),       64'(0));
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);

    // Random sweep with random in_valid and out_ready per instance.
    for (int i = 0; i < NI; i++) base[i] = m_acc[i];
    for (int cyc = 0; cyc < 40000; cyc++) begin
      @(negedge clk);
      all_done = 1;
      for (int i = 0; i < NI; i++) begin
        if (m_acc[i] < base[i] + 1000) all_done = 0;
        in_valid[i]  = ($urandom_range(0, 3) != 0);
        out_ready[i] = ($urandom_range(0, 3) != 0);
        a_in[i]      = 8'($urandom);
        b_in[i]      = 8'($urandom);
        cin_in[i]    = 1'($urandom_range(0, 1));
      end
      if (all_done) break;
    end
    for (int i = 0; i < NI; i++) begin
      check("sweep_1000_ops", i, 64'(m_acc[i] >= base[i] + 1000), 64'(1));
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b1;
    end
    repeat (15) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_adder.md
SEQ_ADDER -- requirements
Module: seq_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and sum width in bits (legal values: 2 to 64).
REQ-002 The block SHALL have parameter CHUNK, default 1, giving the bits added per cycle; WIDTH mod CHUNK SHALL equal 0.
REQ-003 The block SHALL have port clk, input, 1 bit: the single rising-edge clock.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: operands on a, b and cin are valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept operands.
REQ-007 The block SHALL have ports a and b, input, WIDTH bits each: unsigned/two's-complement operands.
REQ-008 The block SHALL have port cin, input, 1 bit: carry-in.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 The block SHALL have port sum, output, WIDTH bits: a + b + cin modulo 2^WIDTH.
REQ-012 The block SHALL have port cout, output, 1 bit: carry out of bit WIDTH-1.
REQ-013 The block SHALL have port ovf, output, 1 bit: signed overflow (carry into MSB XOR carry out of MSB).

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-016 Acceptance SHALL occur on a rising edge with in_valid=1 and in_ready=1; at that edge a, b and cin are captured into internal registers, the chunk counter is cleared, and state becomes RUN.
REQ-017 Each RUN cycle SHALL add chunk k (bits k*CHUNK+CHUNK-1 down to k*CHUNK) of a and b plus the carry register, store the CHUNK result bits into the sum register, update the carry register, and increment k.
REQ-018 After chunk WIDTH/CHUNK-1 is processed, the state SHALL become DONE; sum, cout and ovf SHALL be valid and stable in DONE.
REQ-019 Latency SHALL be exactly WIDTH/CHUNK+1 cycles: out_valid rises WIDTH/CHUNK+1 rising edges after the acceptance edge (edge of acceptance counted as edge 0 is excluded).
REQ-020 ovf SHALL be computed from the carry into bit WIDTH-1 captured during the final chunk.
REQ-021 In DONE with out_ready=0, sum, cout, ovf and out_valid SHALL hold unchanged indefinitely.
REQ-022 In DONE with out_ready=1, the state SHALL return to IDLE on that edge; in_ready SHALL be 1 in the following cycle (no same-cycle re-acceptance).
REQ-023 Changes on a, b, cin or in_valid outside IDLE SHALL have no effect on the result in progress.
REQ-024 out_ready SHALL be ignored outside DONE; in_valid SHALL be ignored outside IDLE.
REQ-025 If CHUNK = WIDTH, RUN SHALL last exactly one cycle (latency 2).
REQ-026 sum, cout and ovf outside DONE are don't-care for consumers, but SHALL only change on rising edges of clk.

Reset
REQ-027 rst_n=0 SHALL immediately, without waiting for clk, force state IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, carry register 0 and chunk counter 0.
REQ-028 Reset asserted in RUN or DONE SHALL abort the operation; the result SHALL never appear after release.
REQ-029 After rst_n deasserts, the first acceptance SHALL be possible on the first rising edge.

Verification
REQ-030 WIDTH=8, CHUNK=1: a=0x00, b=0x00, cin=0 -> sum=0x00, cout=0, ovf=0; out_valid rises exactly 9 edges after acceptance.
REQ-031 WIDTH=8, CHUNK=1: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0; a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1; a=0x80, b=0xFF, cin=1 -> sum=0x80, cout=1, ovf=0.
REQ-032 Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid=1 and sum/cout/ovf constant throughout; in_ready=0 throughout; in_valid pulses ignored.
REQ-033 Reset mid-RUN: assert rst_n=0 at chunk 3 of a=0x55+b=0x33 -> out_valid=0 and in_ready=1 immediately; the next operation a=0x01, b=0x02 gives sum=0x03.
REQ-034 WIDTH=8, CHUNK=4: a=0x9C, b=0x67, cin=1 -> sum=0x04, cout=1, ovf=0, latency 3; a random 1000-vector sweep at CHUNK in {1,2,4,8} matches a golden a+b+cin model.
